// File: rtl/int_regfile_sb_if.sv
// Writeback, decode-read and scoreboard signals between the pipeline and the integer register file.
// The master side drives indices and strobes; the slave (register file) returns read data and busy flags.
interface int_regfile_sb_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
);
  localparam int unsigned AW = $clog2(NREG);

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            iss_en;
  logic [AW-1:0]   iss_rd;
  logic            flush;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            stall;

  modport master (
    output wr_en, wr_addr, wr_data, rs1_addr, rs2_addr, iss_en, iss_rd, flush,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, stall
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rs1_addr, rs2_addr, iss_en, iss_rd, flush,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, stall
  );
endinterface

// File: rtl/int_regfile_sb.sv
// Integer register file x0..x(NREG-1) with two combinational read ports, optional
// write-to-read bypass and a per-register pending-write scoreboard for RAW stalls.
module int_regfile_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter bit          BYPASS = 1'b1
) (
  input logic               clk,
  input logic               rst,
  int_regfile_sb_if.slave   rf
);
  localparam int unsigned AW = $clog2(NREG);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pend;
  logic [NREG-1:0] wr_dec;
  logic [NREG-1:0] iss_dec;
  logic            wr_live;
  logic            fwd1;
  logic            fwd2;

  // Forwarding is masked during reset so the read ports show zero while rst is high.
  assign wr_live = rf.wr_en && !rst;

  always_comb begin
    wr_dec  = '0;
    iss_dec = '0;
    if (rf.wr_en && (rf.wr_addr != '0))
      wr_dec[rf.wr_addr] = 1'b1;
    if (rf.iss_en && (rf.iss_rd != '0))
      iss_dec[rf.iss_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else begin
      for (int unsigned i = 1; i < NREG; i++)
        if (wr_dec[i])
          regs[i] <= rf.wr_data;
    end
  end

  // A new issue wins over a same-cycle writeback: that writeback belongs to the older producer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pend <= '0;
    else if (rf.flush)
      pend <= '0;
    else
      pend <= ((pend & ~wr_dec) | iss_dec) & ~{{(NREG-1){1'b0}}, 1'b1};
  end

  always_comb begin
    fwd1 = BYPASS && wr_live && (rf.wr_addr == rf.rs1_addr) && (rf.rs1_addr != '0);
    fwd2 = BYPASS && wr_live && (rf.wr_addr == rf.rs2_addr) && (rf.rs2_addr != '0);
  end

  always_comb begin
    rf.rs1_data = '0;
    rf.rs2_data = '0;
    if (rf.rs1_addr != '0)
      rf.rs1_data = fwd1 ? rf.wr_data : regs[rf.rs1_addr];
    if (rf.rs2_addr != '0)
      rf.rs2_data = fwd2 ? rf.wr_data : regs[rf.rs2_addr];
  end

  always_comb begin
    rf.rs1_busy = pend[rf.rs1_addr] && !fwd1;
    rf.rs2_busy = pend[rf.rs2_addr] && !fwd2;
    rf.stall    = rf.rs1_busy || rf.rs2_busy;
  end

  logic unused_aw;
  assign unused_aw = ^AW;
endmodule

// File: tb/tb_int_regfile_sb.sv
// Self-checking bench for int_regfile_sb: drives a BYPASS=1 and a BYPASS=0 instance in lockstep
// and checks both against directed vectors and a reference model of the register file rules.
module tb_int_regfile_sb;
    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        iss_en;
    logic [4:0]  iss_rd;
    logic        flush;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_regs [32];
    bit          m_pend [32];

    int_regfile_sb_if #(.XLEN(32), .NREG(32)) bus_b ();
    int_regfile_sb_if #(.XLEN(32), .NREG(32)) bus_n ();

    assign bus_b.wr_en    = wr_en;
    assign bus_b.wr_addr  = wr_addr;
    assign bus_b.wr_data  = wr_data;
    assign bus_b.rs1_addr = rs1_addr;
    assign bus_b.rs2_addr = rs2_addr;
    assign bus_b.iss_en   = iss_en;
    assign bus_b.iss_rd   = iss_rd;
    assign bus_b.flush    = flush;
    assign bus_n.wr_en    = wr_en;
    assign bus_n.wr_addr  = wr_addr;
    assign bus_n.wr_data  = wr_data;
    assign bus_n.rs1_addr = rs1_addr;
    assign bus_n.rs2_addr = rs2_addr;
    assign bus_n.iss_en   = iss_en;
    assign bus_n.iss_rd   = iss_rd;
    assign bus_n.flush    = flush;

    int_regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(1'b1)) dut_b (.clk(clk), .rst(rst), .rf(bus_b));
    int_regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(1'b0)) dut_n (.clk(clk), .rst(rst), .rf(bus_n));

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        ie;
        logic [4:0]  ird;
        logic        fl;
        logic [31:0] b_d1;
        logic [31:0] b_d2;
        logic [1:0]  b_busy;
        logic [31:0] n_d1;
        logic [31:0] n_d2;
        logic [1:0]  n_busy;
    } vec_t;

    vec_t tv [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_data(input logic [4:0] a, input bit byp);
        if (rst || a == 5'd0) return 32'd0;
        if (byp && wr_en && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    function automatic logic m_busy(input logic [4:0] a, input bit byp);
        if (rst) return 1'b0;
        return m_pend[a] && !(byp && wr_en && wr_addr == a);
    endfunction

    task automatic model_update();
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'd0;
                m_pend[i] = 1'b0;
            end
        end else begin
            if (wr_en && wr_addr != 5'd0) m_regs[wr_addr] = wr_data;
            if (flush) begin
                for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
            end else begin
                if (wr_en) m_pend[wr_addr] = 1'b0;
                if (iss_en && iss_rd != 5'd0) m_pend[iss_rd] = 1'b1;
            end
        end
    endtask

    task automatic check_model();
        logic eb1, eb2, en1, en2;
        eb1 = m_busy(rs1_addr, 1'b1);
        eb2 = m_busy(rs2_addr, 1'b1);
        en1 = m_busy(rs1_addr, 1'b0);
        en2 = m_busy(rs2_addr, 1'b0);
        chk("b.rs1_data", bus_b.rs1_data, m_data(rs1_addr, 1'b1));
        chk("b.rs2_data", bus_b.rs2_data, m_data(rs2_addr, 1'b1));
        chk("b.rs1_busy", 32'(bus_b.rs1_busy), 32'(eb1));
        chk("b.rs2_busy", 32'(bus_b.rs2_busy), 32'(eb2));
        chk("b.stall",    32'(bus_b.stall),    32'(eb1 | eb2));
        chk("n.rs1_data", bus_n.rs1_data, m_data(rs1_addr, 1'b0));
        chk("n.rs2_data", bus_n.rs2_data, m_data(rs2_addr, 1'b0));
        chk("n.rs1_busy", 32'(bus_n.rs1_busy), 32'(en1));
        chk("n.rs2_busy", 32'(bus_n.rs2_busy), 32'(en2));
        chk("n.stall",    32'(bus_n.stall),    32'(en1 | en2));
    endtask

    task automatic settle();
        @(negedge clk);
        check_model();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; iss_en = 1'b0; iss_rd = '0; flush = 1'b0;
    endtask

    initial begin
        // we wa wd r1 r2 ie ird fl | bypass: d1 d2 busy | no-bypass: d1 d2 busy
        tv[0]  = '{1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 0, 32'hDEADBEEF, 0, 2'b00, 0, 0, 2'b00};
        tv[1]  = '{0, 0, 0, 5, 5, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00};
        tv[2]  = '{1, 0, 32'h12345678, 0, 5, 0, 0, 0, 0, 32'hDEADBEEF, 2'b00, 0, 32'hDEADBEEF, 2'b00};
        tv[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00};
        tv[4]  = '{0, 0, 0, 3, 5, 1, 3, 0, 0, 32'hDEADBEEF, 2'b00, 0, 32'hDEADBEEF, 2'b00};
        tv[5]  = '{0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 2'b10};
        tv[6]  = '{1, 3, 32'h11111111, 3, 0, 0, 0, 0, 32'h11111111, 0, 2'b00, 0, 0, 2'b10};
        tv[7]  = '{0, 0, 0, 3, 0, 0, 0, 0, 32'h11111111, 0, 2'b00, 32'h11111111, 0, 2'b00};
        tv[8]  = '{1, 3, 32'h22222222, 3, 0, 1, 3, 0, 32'h22222222, 0, 2'b00, 32'h11111111, 0, 2'b00};
        tv[9]  = '{0, 0, 0, 3, 0, 0, 0, 0, 32'h22222222, 0, 2'b10, 32'h22222222, 0, 2'b10};
        tv[10] = '{1, 3, 32'h33333333, 3, 7, 1, 7, 0, 32'h33333333, 0, 2'b00, 32'h22222222, 0, 2'b10};
        tv[11] = '{1, 7, 32'hA5A5A5A5, 3, 7, 0, 0, 0, 32'h33333333, 32'hA5A5A5A5, 2'b00, 32'h33333333, 0, 2'b01};
        tv[12] = '{0, 0, 0, 7, 3, 0, 0, 0, 32'hA5A5A5A5, 32'h33333333, 2'b00, 32'hA5A5A5A5, 32'h33333333, 2'b00};
        tv[13] = '{0, 0, 0, 4, 9, 1, 4, 0, 0, 0, 2'b00, 0, 0, 2'b00};
        tv[14] = '{0, 0, 0, 4, 9, 1, 9, 0, 0, 0, 2'b10, 0, 0, 2'b10};
        tv[15] = '{0, 0, 0, 4, 9, 0, 0, 1, 0, 0, 2'b11, 0, 0, 2'b11};
        tv[16] = '{0, 0, 0, 4, 9, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00};
        tv[17] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00};
        tv[18] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00};
        tv[19] = '{0, 0, 0, 6, 0, 1, 6, 1, 0, 0, 2'b00, 0, 0, 2'b00};
        tv[20] = '{0, 0, 0, 6, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00};

        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_pend[i] = 1'b0;
        end

        // Reset held: every read port and flag is zero, even with a live write to the read index.
        rst = 1'b1; idle(); rs1_addr = '0; rs2_addr = '0;
        for (int a = 1; a < 32; a++) begin
            wr_en = 1'b1; wr_addr = 5'(a); wr_data = 32'hFFFFFFFF;
            rs1_addr = 5'(a); rs2_addr = 5'(32 - a);
            #1;
            chk("rst.b.rs1_data", bus_b.rs1_data, 32'd0);
            chk("rst.b.rs2_data", bus_b.rs2_data, 32'd0);
            chk("rst.n.rs1_data", bus_n.rs1_data, 32'd0);
            chk("rst.n.rs2_data", bus_n.rs2_data, 32'd0);
            chk("rst.flags", {27'd0, bus_b.rs1_busy, bus_b.rs2_busy, bus_b.stall, bus_n.stall, bus_n.rs1_busy}, 32'd0);
        end
        idle();
        @(posedge clk); model_update(); #1;
        rst = 1'b0; rs1_addr = 5'd1; rs2_addr = 5'd31;
        settle();
        advance();

        for (int i = 0; i < 21; i++) begin
            wr_en = tv[i].we; wr_addr = tv[i].wa; wr_data = tv[i].wd;
            rs1_addr = tv[i].r1; rs2_addr = tv[i].r2;
            iss_en = tv[i].ie; iss_rd = tv[i].ird; flush = tv[i].fl;
            settle();
            chk($sformatf("tv%0d.b.rs1_data", i), bus_b.rs1_data, tv[i].b_d1);
            chk($sformatf("tv%0d.b.rs2_data", i), bus_b.rs2_data, tv[i].b_d2);
            chk($sformatf("tv%0d.b.busy", i), 32'({bus_b.rs1_busy, bus_b.rs2_busy}), 32'(tv[i].b_busy));
            chk($sformatf("tv%0d.b.stall", i), 32'(bus_b.stall), 32'(|tv[i].b_busy));
            chk($sformatf("tv%0d.n.rs1_data", i), bus_n.rs1_data, tv[i].n_d1);
            chk($sformatf("tv%0d.n.rs2_data", i), bus_n.rs2_data, tv[i].n_d2);
            chk($sformatf("tv%0d.n.busy", i), 32'({bus_n.rs1_busy, bus_n.rs2_busy}), 32'(tv[i].n_busy));
            chk($sformatf("tv%0d.n.stall", i), 32'(bus_n.stall), 32'(|tv[i].n_busy));
            advance();
        end

        // Random traffic, addresses biased to a small set so hazards and bypass hits are frequent.
        for (int c = 0; c < 400; c++) begin
            wr_en    = ($urandom_range(0, 99) < 60);
            wr_addr  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            wr_data  = $urandom;
            rs1_addr = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            rs2_addr = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            iss_en   = ($urandom_range(0, 99) < 50);
            iss_rd   = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            flush    = ($urandom_range(0, 99) < 4);
            settle();
            advance();
        end

        // Mid-operation reset: x9 and pend[4] hold state, then rst rises while x9 is being written.
        idle(); wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h00000055; iss_en = 1'b1; iss_rd = 5'd4;
        rs1_addr = 5'd9; rs2_addr = 5'd4;
        settle(); advance();
        idle(); rs1_addr = 5'd9; rs2_addr = 5'd4;
        settle();
        chk("pre.n.rs1_data", bus_n.rs1_data, 32'h00000055);
        chk("pre.n.rs2_busy", 32'(bus_n.rs2_busy), 32'd1);
        advance();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h00000001;
        rst = 1'b1;
        #1;
        chk("async.b.rs1_data", bus_b.rs1_data, 32'd0);
        chk("async.n.rs1_data", bus_n.rs1_data, 32'd0);
        chk("async.b.stall", 32'(bus_b.stall), 32'd0);
        chk("async.n.rs2_busy", 32'(bus_n.rs2_busy), 32'd0);
        settle(); advance();
        rst = 1'b0; idle(); rs1_addr = 5'd9; rs2_addr = 5'd4;
        settle();
        chk("post.b.rs1_data", bus_b.rs1_data, 32'd0);
        chk("post.n.rs1_data", bus_n.rs1_data, 32'd0);
        chk("post.n.stall", 32'(bus_n.stall), 32'd0);
        advance();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end
endmodule
